// File: rtl/bayes_pkg.sv
// -----------------------------------------------------------------------------
// bayes_pkg
// Constants and types shared by the p(x|c) read-data path of the Bayes MNIST
// classifier: class/attribute counts, index widths and the FSM state type
// of the accumulate/argmax block.
// No ports (package).
// -----------------------------------------------------------------------------
package bayes_pkg;

   localparam int NUM_CLASS    = 10;
   localparam int NUM_ATTR     = 784;
   localparam int NUM_TERMS    = NUM_CLASS * NUM_ATTR;
   localparam int PXC_BASE_ONE = 7840;

   localparam int C_IDX_W = 4;
   localparam int A_IDX_W = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_ARGMAX = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/pxc_accum_argmax_if.sv
// -----------------------------------------------------------------------------
// pxc_accum_argmax_if
// p(x|c) table read interface: the read enable and indices issued by the
// address stage, plus the signed data word returned by the BRAM.
//   in_vld        read enable (ena_pxc)
//   in_c_idx      class index travelling with in_vld
//   in_attri_idx  attribute index travelling with in_vld
//   pxc_dout      signed BRAM data, RD_LAT cycles after in_vld
// master: address stage / BRAM side.  slave: accumulator side.
// -----------------------------------------------------------------------------
interface pxc_accum_argmax_if
   import bayes_pkg::*;
#(
   parameter int DW = 16
);

   logic                 in_vld;
   logic [C_IDX_W-1:0]   in_c_idx;
   logic [A_IDX_W-1:0]   in_attri_idx;
   logic signed [DW-1:0] pxc_dout;

   modport master (
      output in_vld,
      output in_c_idx,
      output in_attri_idx,
      output pxc_dout
   );

   modport slave (
      input in_vld,
      input in_c_idx,
      input in_attri_idx,
      input pxc_dout
   );

endinterface

// File: rtl/rd_align_pipe.sv
// -----------------------------------------------------------------------------
// rd_align_pipe
// Delays the read valid and its class/attribute indices by RD_LAT cycles so
// they line up with the BRAM data word.
//   clk, rst       clock, synchronous active-high reset
//   flush          synchronous clear of the valid bits only
//   in_vld, in_c_idx, in_attri_idx   address-stage request
//   vld_out, c_out, a_out            request delayed by RD_LAT cycles
// -----------------------------------------------------------------------------
module rd_align_pipe
   import bayes_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_vld,
   input  logic [C_IDX_W-1:0] in_c_idx,
   input  logic [A_IDX_W-1:0] in_attri_idx,
   output logic               vld_out,
   output logic [C_IDX_W-1:0] c_out,
   output logic [A_IDX_W-1:0] a_out
);

   logic [RD_LAT-1:0]  vld_p;
   logic [C_IDX_W-1:0] c_p [RD_LAT];
   logic [A_IDX_W-1:0] a_p [RD_LAT];

   // stage p0..p(RD_LAT-1): valid is control and is cleared; indices are not
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= in_vld;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_p[i] <= vld_p[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      c_p[0] <= in_c_idx;
      a_p[0] <= in_attri_idx;
      for (int i = 1; i < RD_LAT; i++) begin
         c_p[i] <= c_p[i-1];
         a_p[i] <= a_p[i-1];
      end
   end

   assign vld_out = vld_p[RD_LAT-1];
   assign c_out   = c_p[RD_LAT-1];
   assign a_out   = a_p[RD_LAT-1];

endmodule

// File: rtl/pxc_accum_argmax.sv
// -----------------------------------------------------------------------------
// pxc_accum_argmax
// Accumulates signed log-likelihood terms p(x|c) per class over all
// attributes, then scans the class scores for the maximum (lowest index wins
// ties) and reports the winning digit.
//   clk, rst       clock, synchronous active-high reset
//   start          one-cycle pulse, clears scores and begins a classification
//   rd             p(x|c) read interface (slave): valid, indices, BRAM data
//   busy           high while accumulating or scanning
//   result_vld     one-cycle pulse when result_class/result_score update
//   result_class   winning class, held until replaced
//   result_score   winning accumulated score, held until replaced
// -----------------------------------------------------------------------------
module pxc_accum_argmax
   import bayes_pkg::*;
#(
   parameter int DW        = 16,
   parameter int ACC_W     = 26,
   parameter int RD_LAT    = 1,
   parameter int NUM_CLASS = bayes_pkg::NUM_CLASS,
   parameter int NUM_ATTR  = bayes_pkg::NUM_ATTR
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   pxc_accum_argmax_if.slave       rd,
   output logic                    busy,
   output logic                    result_vld,
   output logic [C_IDX_W-1:0]      result_class,
   output logic signed [ACC_W-1:0] result_score
);

   localparam int CNT_W = $clog2(NUM_CLASS * NUM_ATTR + 1);
   localparam logic [CNT_W-1:0]   TERM_LAST = CNT_W'(NUM_CLASS * NUM_ATTR - 1);
   localparam logic [C_IDX_W-1:0] C_LIM     = C_IDX_W'(NUM_CLASS);
   localparam logic [A_IDX_W-1:0] A_LIM     = A_IDX_W'(NUM_ATTR);

   function automatic logic signed [ACC_W-1:0] sext(input logic signed [DW-1:0] d);
      return ACC_W'(d);
   endfunction

   state_t state_q, state_d;

   logic                    al_vld;
   logic [C_IDX_W-1:0]      al_c;
   logic [A_IDX_W-1:0]      al_a;
   logic                    clr;
   logic                    acc_hit;
   logic [CNT_W-1:0]        term_cnt;
   logic [C_IDX_W-1:0]      scan_idx;
   logic signed [ACC_W-1:0] best;
   logic [C_IDX_W-1:0]      best_idx;
   logic signed [ACC_W-1:0] score_q [NUM_CLASS];

   // a start accepted from IDLE/DONE also drops anything still in flight
   assign clr = start && (state_q == ST_IDLE || state_q == ST_DONE);

   rd_align_pipe #(.RD_LAT(RD_LAT)) u_align (
      .clk          (clk),
      .rst          (rst),
      .flush        (clr),
      .in_vld       (rd.in_vld),
      .in_c_idx     (rd.in_c_idx),
      .in_attri_idx (rd.in_attri_idx),
      .vld_out      (al_vld),
      .c_out        (al_c),
      .a_out        (al_a)
   );

   assign acc_hit = (state_q == ST_ACCUM) && al_vld && (al_c < C_LIM) && (al_a < A_LIM);
   assign busy    = (state_q == ST_ACCUM) || (state_q == ST_ARGMAX);

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: if (start) state_d = ST_ACCUM;
         // leave on the edge that accumulates the final term
         ST_ACCUM:         if (acc_hit && term_cnt == TERM_LAST) state_d = ST_ARGMAX;
         ST_ARGMAX:        if (scan_idx == C_LIM) state_d = ST_DONE;
         default:          state_d = ST_IDLE;
      endcase
   end

   // accumulate stage: aligned data into per-class score
   always_ff @(posedge clk) begin
      if (rst) begin
         term_cnt <= '0;
         for (int i = 0; i < NUM_CLASS; i++) score_q[i] <= '0;
      end else if (clr) begin
         term_cnt <= '0;
         for (int i = 0; i < NUM_CLASS; i++) score_q[i] <= '0;
      end else if (acc_hit) begin
         term_cnt       <= term_cnt + 1'b1;
         score_q[al_c]  <= score_q[al_c] + sext(rd.pxc_dout);
      end
   end

   // argmax stage: scan_idx 0 loads, 1..NUM_CLASS-1 compare, NUM_CLASS reports
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_idx     <= '0;
         best         <= '0;
         best_idx     <= '0;
         result_vld   <= 1'b0;
         result_class <= '0;
         result_score <= '0;
      end else begin
         result_vld <= 1'b0;
         if (state_q != ST_ARGMAX) begin
            scan_idx <= '0;
         end else begin
            scan_idx <= scan_idx + 1'b1;
            if (scan_idx == '0) begin
               best     <= score_q[0];
               best_idx <= '0;
            end else if (scan_idx < C_LIM) begin
               if (score_q[scan_idx] > best) begin
                  best     <= score_q[scan_idx];
                  best_idx <= scan_idx;
               end
            end else begin
               result_class <= best_idx;
               result_score <= best;
               result_vld   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pxc_accum_argmax.sv
// -----------------------------------------------------------------------------
// tb_pxc_accum_argmax
// Drives one request stream into two instances (RD_LAT=1 and RD_LAT=3), each
// fed by its own BRAM model of matching latency, and compares their results
// with a per-class sum / first-maximum reference over the table contents.
// -----------------------------------------------------------------------------
module tb_pxc_accum_argmax;
   import bayes_pkg::*;

   localparam int NT = NUM_TERMS;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, in_vld;
   logic [3:0] in_c;
   logic [9:0] in_a;

   pxc_accum_argmax_if #(.DW(16)) rd1 ();
   pxc_accum_argmax_if #(.DW(16)) rd3 ();

   assign rd1.in_vld = in_vld;  assign rd1.in_c_idx = in_c;  assign rd1.in_attri_idx = in_a;
   assign rd3.in_vld = in_vld;  assign rd3.in_c_idx = in_c;  assign rd3.in_attri_idx = in_a;

   logic signed [15:0] mem [10][784];
   logic signed [15:0] q1, q3a, q3b, q3c;
   assign rd1.pxc_dout = q1;
   assign rd3.pxc_dout = q3c;

   function automatic logic signed [15:0] rd_mem(input logic [3:0] c, input logic [9:0] a);
      if (c < 4'd10 && a < 10'd784) return mem[c][a];
      return 16'sh1234;
   endfunction

   always @(posedge clk) begin
      q1  <= rd_mem(in_c, in_a);
      q3a <= rd_mem(in_c, in_a);
      q3b <= q3a;
      q3c <= q3b;
   end

   logic        busy1, vld1, busy3, vld3;
   logic [3:0]  cls1, cls3;
   logic signed [25:0] sc1, sc3;

   pxc_accum_argmax #(.DW(16), .ACC_W(26), .RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .rd(rd1),
      .busy(busy1), .result_vld(vld1), .result_class(cls1), .result_score(sc1));

   pxc_accum_argmax #(.DW(16), .ACC_W(26), .RD_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .start(start), .rd(rd3),
      .busy(busy3), .result_vld(vld3), .result_class(cls3), .result_score(sc3));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int pulses [2] = '{0, 0};
   int vcyc   [2] = '{0, 0};
   always @(negedge clk) begin
      if (vld1 === 1'b1) begin pulses[0]++; vcyc[0] = cyc; end
      if (vld3 === 1'b1) begin pulses[1]++; vcyc[1] = cyc; end
   end

   int errors = 0;
   int checks = 0;

   int perm [NT];
   int junk_cnt [NT];
   int base_p [2];
   int lat [2], npul [2], ocls [2];
   logic signed [25:0] osc [2];
   logic bmid [2], bend [2];
   int exp_lat [2] = '{12, 14};

   task automatic drive(input bit v, input int c, input int a, input bit st);
      in_vld = v; in_c = 4'(c); in_a = 10'(a); start = st;
      @(posedge clk); #1;
      in_vld = 1'b0; start = 1'b0;
   endtask

   task automatic fill(input int kind);
      for (int c = 0; c < 10; c++)
         for (int a = 0; a < 784; a++)
            case (kind)
               0: mem[c][a] = (c == 7) ? -16'sd1 : -16'sd2;
               1: mem[c][a] = 16'sd0;
               2: mem[c][a] = (c == 9) ? 16'sh7FFF : 16'sh8000;
               3: mem[c][a] = (c == 2) ? 16'sd0 : -16'sd5;
               default: mem[c][a] = 16'($urandom);
            endcase
   endtask

   task automatic model(output int ecls, output logic signed [25:0] esc);
      longint s, best;
      best = 0; ecls = 0;
      for (int c = 0; c < 10; c++) begin
         s = 0;
         for (int a = 0; a < 784; a++) s += longint'(mem[c][a]);
         if (c == 0 || s > best) begin best = s; ecls = c; end
      end
      esc = best[25:0];
   endtask

   task automatic start_run();
      base_p[0] = pulses[0];
      base_p[1] = pulses[1];
      drive(0, 0, 0, 1);
   endtask

   // order: 0 class-major, 1 attribute-major, 2 random permutation
   task automatic feed(input int order, input int junk_n, input bit busy_starts,
                       input int n_terms, output int last_k);
      int c, a, t;
      last_k = cyc;
      for (int i = 0; i < NT; i++) begin perm[i] = i; junk_cnt[i] = 0; end
      if (order == 2)
         for (int i = NT - 1; i > 0; i--) begin
            int j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
         end
      repeat (junk_n) junk_cnt[$urandom_range(0, NT - 1)]++;
      for (int j = 0; j < n_terms; j++) begin
         for (int k = 0; k < junk_cnt[j]; k++)
            if ($urandom_range(0, 1) == 1) drive(1, 12, $urandom_range(0, 783), 0);
            else                           drive(1, $urandom_range(0, 9), 784, 0);
         if ($urandom_range(0, 31) == 0) drive(0, 0, 0, 0);
         if (order == 1) begin c = perm[j] % 10;  a = perm[j] / 10;  end
         else            begin c = perm[j] / 784; a = perm[j] % 784; end
         drive(1, c, a, busy_starts && (j == 100 || j == 5000));
         last_k = cyc;
      end
   endtask

   task automatic finish_run(input int last_k, input bit busy_starts);
      bmid[0] = 1'b0; bmid[1] = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (busy_starts && i == 3) start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         if (cyc == last_k + 5) begin bmid[0] = busy1; bmid[1] = busy3; end
      end
      lat[0] = vcyc[0] - last_k;        lat[1] = vcyc[1] - last_k;
      npul[0] = pulses[0] - base_p[0];  npul[1] = pulses[1] - base_p[1];
      ocls[0] = int'(cls1);             ocls[1] = int'(cls3);
      osc[0] = sc1;                     osc[1] = sc3;
      bend[0] = busy1;                  bend[1] = busy3;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; in_vld = 1'b0; in_c = '0; in_a = '0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (busy1 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL reset busy: got %b/%b want 0", busy1, busy3); end
      checks++; if (vld1 !== 1'b0 || vld3 !== 1'b0) begin errors++; $display("FAIL reset result_vld: got %b/%b want 0", vld1, vld3); end
      checks++; if (cls1 !== 4'd0 || cls3 !== 4'd0) begin errors++; $display("FAIL reset result_class: got %0d/%0d want 0", cls1, cls3); end
      checks++; if (sc1 !== 26'sd0 || sc3 !== 26'sd0) begin errors++; $display("FAIL reset result_score: got %0d/%0d want 0", sc1, sc3); end
   endtask

   task automatic test_neg_dominant();
      int lk, ec; logic signed [25:0] es;
      fill(0); model(ec, es);
      start_run(); feed(0, 0, 0, NT, lk); finish_run(lk, 0);
      for (int d = 0; d < 2; d++) begin
         checks++; if (ocls[d] !== 7 || ocls[d] !== ec) begin errors++; $display("FAIL neg class dut%0d: got %0d want 7", d, ocls[d]); end
         checks++; if (osc[d] !== -26'sd784 || osc[d] !== es) begin errors++; $display("FAIL neg score dut%0d: got %0d want -784", d, osc[d]); end
         checks++; if (lat[d] !== exp_lat[d]) begin errors++; $display("FAIL neg latency dut%0d: got %0d want %0d", d, lat[d], exp_lat[d]); end
         checks++; if (npul[d] !== 1) begin errors++; $display("FAIL neg pulses dut%0d: got %0d want 1", d, npul[d]); end
         checks++; if (bmid[d] !== 1'b1 || bend[d] !== 1'b0) begin errors++; $display("FAIL neg busy dut%0d: got %b,%b want 1,0", d, bmid[d], bend[d]); end
      end
   endtask

   task automatic test_all_zero();
      int lk;
      fill(1);
      start_run(); feed(2, 0, 0, NT, lk); finish_run(lk, 0);
      for (int d = 0; d < 2; d++) begin
         checks++; if (ocls[d] !== 0) begin errors++; $display("FAIL zero class dut%0d: got %0d want 0", d, ocls[d]); end
         checks++; if (osc[d] !== 26'sd0) begin errors++; $display("FAIL zero score dut%0d: got %0d want 0", d, osc[d]); end
         checks++; if (npul[d] !== 1) begin errors++; $display("FAIL zero pulse width dut%0d: got %0d cycles want 1", d, npul[d]); end
         checks++; if (lat[d] !== exp_lat[d]) begin errors++; $display("FAIL zero latency dut%0d: got %0d want %0d", d, lat[d], exp_lat[d]); end
      end
   endtask

   task automatic test_extremes();
      int lk;
      fill(2);
      start_run(); feed(1, 0, 0, NT, lk); finish_run(lk, 0);
      for (int d = 0; d < 2; d++) begin
         checks++; if (ocls[d] !== 9) begin errors++; $display("FAIL extreme class dut%0d: got %0d want 9", d, ocls[d]); end
         checks++; if (osc[d] !== 26'sd25689328) begin errors++; $display("FAIL extreme score dut%0d: got %0d want 25689328", d, osc[d]); end
         checks++; if (lat[d] !== exp_lat[d]) begin errors++; $display("FAIL extreme latency dut%0d: got %0d want %0d", d, lat[d], exp_lat[d]); end
      end
   endtask

   task automatic test_out_of_range();
      int lk, ec; logic signed [25:0] es;
      fill(4); model(ec, es);
      start_run(); feed(2, 50, 1, NT, lk); finish_run(lk, 1);
      for (int d = 0; d < 2; d++) begin
         checks++; if (ocls[d] !== ec) begin errors++; $display("FAIL oor class dut%0d: got %0d want %0d", d, ocls[d], ec); end
         checks++; if (osc[d] !== es) begin errors++; $display("FAIL oor score dut%0d: got %0d want %0d", d, osc[d], es); end
         checks++; if (lat[d] !== exp_lat[d]) begin errors++; $display("FAIL oor latency dut%0d: got %0d want %0d", d, lat[d], exp_lat[d]); end
         checks++; if (npul[d] !== 1) begin errors++; $display("FAIL oor pulses dut%0d: got %0d want 1", d, npul[d]); end
      end
   endtask

   task automatic test_reset_abort();
      int lk, ec; logic signed [25:0] es;
      fill(4);
      start_run(); feed(0, 0, 0, 4000, lk);
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      checks++; if (busy1 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL abort busy: got %b/%b want 0", busy1, busy3); end
      checks++; if (cls1 !== 4'd0 || sc1 !== 26'sd0 || cls3 !== 4'd0 || sc3 !== 26'sd0) begin errors++; $display("FAIL abort result cleared: got %0d,%0d/%0d,%0d want 0", cls1, sc1, cls3, sc3); end
      repeat (20) begin @(posedge clk); #1; end
      checks++; if (pulses[0] != base_p[0] || pulses[1] != base_p[1]) begin errors++; $display("FAIL abort stray result_vld: got %0d/%0d pulses want 0", pulses[0] - base_p[0], pulses[1] - base_p[1]); end
      fill(3); model(ec, es);
      start_run(); feed(2, 0, 0, NT, lk); finish_run(lk, 0);
      for (int d = 0; d < 2; d++) begin
         checks++; if (ocls[d] !== 2 || ocls[d] !== ec) begin errors++; $display("FAIL fresh class dut%0d: got %0d want 2", d, ocls[d]); end
         checks++; if (osc[d] !== 26'sd0 || osc[d] !== es) begin errors++; $display("FAIL fresh score dut%0d: got %0d want 0", d, osc[d]); end
         checks++; if (npul[d] !== 1) begin errors++; $display("FAIL fresh pulses dut%0d: got %0d want 1", d, npul[d]); end
      end
   endtask

   task automatic test_back_to_back();
      int lk, eca, ecb; logic signed [25:0] esa, esb;
      fill(4); model(eca, esa);
      start_run(); feed(2, 0, 0, NT, lk); finish_run(lk, 0);
      for (int d = 0; d < 2; d++) begin
         checks++; if (ocls[d] !== eca || osc[d] !== esa) begin errors++; $display("FAIL b2b first dut%0d: got %0d,%0d want %0d,%0d", d, ocls[d], osc[d], eca, esa); end
      end
      repeat (5) begin @(posedge clk); #1; end
      checks++; if (int'(cls1) !== eca || sc1 !== esa || int'(cls3) !== eca || sc3 !== esa) begin errors++; $display("FAIL b2b hold: got %0d,%0d/%0d,%0d want %0d,%0d", cls1, sc1, cls3, sc3, eca, esa); end
      checks++; if (vld1 !== 1'b0 || vld3 !== 1'b0 || busy1 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL b2b idle: got vld %b/%b busy %b/%b want 0", vld1, vld3, busy1, busy3); end
      fill(4); model(ecb, esb);
      start_run(); feed(0, 0, 0, NT, lk); finish_run(lk, 0);
      for (int d = 0; d < 2; d++) begin
         checks++; if (ocls[d] !== ecb) begin errors++; $display("FAIL b2b second class dut%0d: got %0d want %0d", d, ocls[d], ecb); end
         checks++; if (osc[d] !== esb) begin errors++; $display("FAIL b2b second score dut%0d: got %0d want %0d", d, osc[d], esb); end
         checks++; if (lat[d] !== exp_lat[d]) begin errors++; $display("FAIL b2b second latency dut%0d: got %0d want %0d", d, lat[d], exp_lat[d]); end
      end
   endtask

   initial begin
      test_reset();
      test_neg_dominant();
      test_all_zero();
      test_extremes();
      test_out_of_range();
      test_reset_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
